irq_aggregator: RTL and testbench

Parametrised interrupt aggregator between chip-level interrupt sources and the Cortex-M0 core's `IRQ`/`NMI` inputs. It generalises the fixed 16-line core interrupt hookup:
- any number of sources up to 32;
- per-source edge/level mode, polarity and mask;
- software-set pending bits;
- NMI steering.

Firmware controls it through an AHB-Lite slave register port on the system bus.

---
 rtl/irq_aggregator_pkg.sv | 68 ++++++
 rtl/irq_aggregator_src_chan.sv | 52 +++++
 rtl/irq_aggregator.sv | 208 ++++++++++++++++++++
 tb/tb_irq_aggregator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg: register map, AHB encodings and shared types for the interrupt aggregator.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package irq_aggregator_pkg;

    // Register word offsets within the slave window
    localparam logic [31:0] OFF_RAW   = 32'h00;
    localparam logic [31:0] OFF_PEND  = 32'h04;
    localparam logic [31:0] OFF_MASK  = 32'h08;
    localparam logic [31:0] OFF_MODE  = 32'h0C;
    localparam logic [31:0] OFF_POL   = 32'h10;
    localparam logic [31:0] OFF_SWSET = 32'h14;
    localparam logic [31:0] OFF_NMI   = 32'h18;

    // AHB-Lite encodings used by the slave
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ERR1,
        ERR2
    } err_state_t;

    typedef enum logic [2:0] {
        SEL_RAW,
        SEL_PEND,
        SEL_MASK,
        SEL_MODE,
        SEL_POL,
        SEL_SWSET,
        SEL_NMI
    } reg_sel_t;

    // Result of decoding an address-phase offset
    typedef struct packed {
        logic     ok;
        reg_sel_t sel;
    } dec_t;

    // Captured address phase, consumed in the following data phase
    typedef struct packed {
        logic     vld;
        logic     wr;
        reg_sel_t sel;
    } dphase_t;

    function automatic dec_t addr_decode(input logic [31:0] addr);
        dec_t d;
        d.ok  = 1'b1;
        d.sel = SEL_RAW;
        case (addr)
            OFF_RAW:   d.sel = SEL_RAW;
            OFF_PEND:  d.sel = SEL_PEND;
            OFF_MASK:  d.sel = SEL_MASK;
            OFF_MODE:  d.sel = SEL_MODE;
            OFF_POL:   d.sel = SEL_POL;
            OFF_SWSET: d.sel = SEL_SWSET;
            OFF_NMI:   d.sel = SEL_NMI;
            default:   d.ok  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/irq_aggregator_src_chan.sv
// irq_src_chan: one interrupt source - 2-flop sync, polarity, edge detect, sticky pending bit.
// Latency: src to act 2 edges; edge event to pend_q 1 further edge.
// Backpressure: none; set beats clear when both arrive in the same cycle.
module irq_src_chan (
    input  logic core_clk,
    input  logic arst_n,
    input  logic src,
    input  logic pol,
    input  logic mode,
    input  logic sw_set,
    input  logic clr,
    output logic act,
    output logic pend
);

    logic sync1_q;
    logic sync2_q;
    logic act_d_q;
    logic pend_q;
    logic edge_evt;

    assign act      = sync2_q ^ pol;
    assign edge_evt = mode & act & ~act_d_q;

    // Synchronise the async source and keep the previous act for rising-edge detection
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            act_d_q <= 1'b0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
            act_d_q <= act;
        end
    end

    // Sticky pending bit: a new event must never be lost to a concurrent W1C
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_q <= 1'b0;
        end else if (edge_evt | sw_set) begin
            pend_q <= 1'b1;
        end else if (clr) begin
            pend_q <= 1'b0;
        end
    end

    // Level-mode sources show through directly so W1C cannot hide an active line
    assign pend = pend_q | (act & ~mode);

endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: AHB-Lite programmable interrupt aggregator driving core IRQ lines and NMI.
// Latency: level source -> IRQ/NMI 3 HCLK edges, edge source 4; MASK/PEND/SWSET write -> IRQ 1 edge after data phase.
// Backpressure: OKAY transfers are zero-wait; illegal accesses insert one wait cycle for the two-cycle ERROR.
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int NUM_SRC = 32,
    parameter int NUM_IRQ = 16,
    parameter int ADDR_W  = 12
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [3:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [NUM_IRQ-1:0] IRQ,
    output logic               NMI
);

    err_state_t         state;
    dphase_t            dp;
    logic               hresp_q;
    logic               hreadyout_q;

    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] pol_q;
    logic               nmi_en_q;
    logic [4:0]         nmi_idx_q;

    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] pend;

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] irq_next;
    logic               nmi_q;
    logic               nmi_next;

    logic [31:0]        haddr_w;
    logic [31:0]        act_w;
    logic [31:0]        pend_w;
    logic [31:0]        mask_w;
    logic [31:0]        mode_w;
    logic [31:0]        pol_w;
    logic [31:0]        rdata;

    dec_t               dec;
    logic               addr_vld;
    logic               capture;
    logic               acc_ok;
    logic               wr_hit;
    logic               pend_clr_hit;
    logic               swset_hit;

    // Zero-extend the decoded address so the offset compare is width independent
    always_comb begin
        haddr_w             = '0;
        haddr_w[ADDR_W-1:0] = HADDR;
    end

    assign dec      = addr_decode(haddr_w);
    assign addr_vld = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    // The first ERROR cycle holds HREADY low, so nothing presented then is a real address phase
    assign capture  = addr_vld & (state != ERR1);
    assign acc_ok   = dec.ok & (HSIZE == {1'b0, HSIZE_WORD});

    // Address-phase capture and ERROR response sequencing with registered HRESP/HREADYOUT
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= IDLE;
            dp          <= '0;
            hresp_q     <= HRESP_OKAY;
            hreadyout_q <= 1'b1;
        end else begin
            dp.vld <= 1'b0;
            case (state)
                ERR1: begin
                    state       <= ERR2;
                    hresp_q     <= HRESP_ERROR;
                    hreadyout_q <= 1'b1;
                end
                default: begin
                    if (capture && !acc_ok) begin
                        state       <= ERR1;
                        hresp_q     <= HRESP_ERROR;
                        hreadyout_q <= 1'b0;
                    end else begin
                        state       <= IDLE;
                        hresp_q     <= HRESP_OKAY;
                        hreadyout_q <= 1'b1;
                        if (capture) begin
                            dp.vld <= 1'b1;
                            dp.wr  <= HWRITE;
                            dp.sel <= dec.sel;
                        end
                    end
                end
            endcase
        end
    end

    assign wr_hit       = dp.vld & dp.wr;
    assign pend_clr_hit = wr_hit & (dp.sel == SEL_PEND);
    assign swset_hit    = wr_hit & (dp.sel == SEL_SWSET);

    // Configuration registers commit at the end of an OKAY write data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mask_q    <= '0;
            mode_q    <= '0;
            pol_q     <= '0;
            nmi_en_q  <= 1'b0;
            nmi_idx_q <= '0;
        end else if (wr_hit) begin
            case (dp.sel)
                SEL_MASK: mask_q <= HWDATA[NUM_SRC-1:0];
                SEL_MODE: mode_q <= HWDATA[NUM_SRC-1:0];
                SEL_POL:  pol_q  <= HWDATA[NUM_SRC-1:0];
                SEL_NMI: begin
                    nmi_en_q  <= HWDATA[7];
                    nmi_idx_q <= HWDATA[4:0];
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
        irq_src_chan u_chan (
            .core_clk (HCLK),
            .arst_n   (HRESETn),
            .src      (irq_src[i]),
            .pol      (pol_q[i]),
            .mode     (mode_q[i]),
            .sw_set   (swset_hit & HWDATA[i]),
            .clr      (pend_clr_hit & HWDATA[i]),
            .act      (act[i]),
            .pend     (pend[i])
        );
    end

    // Pad per-source vectors to bus width; unimplemented sources read as zero
    always_comb begin
        act_w                = '0;
        pend_w               = '0;
        mask_w               = '0;
        mode_w               = '0;
        pol_w                = '0;
        act_w[NUM_SRC-1:0]   = act;
        pend_w[NUM_SRC-1:0]  = pend;
        mask_w[NUM_SRC-1:0]  = mask_q;
        mode_w[NUM_SRC-1:0]  = mode_q;
        pol_w[NUM_SRC-1:0]   = pol_q;
    end

    // Read data is only driven during an OKAY read data phase
    always_comb begin
        rdata = '0;
        if (dp.vld && !dp.wr) begin
            case (dp.sel)
                SEL_RAW:  rdata = act_w;
                SEL_PEND: rdata = pend_w;
                SEL_MASK: rdata = mask_w;
                SEL_MODE: rdata = mode_w;
                SEL_POL:  rdata = pol_w;
                SEL_NMI:  rdata = {24'h0, nmi_en_q, 2'b00, nmi_idx_q};
                default:  rdata = '0;
            endcase
        end
    end

    // Fold masked pending sources onto IRQ lines modulo NUM_IRQ
    always_comb begin
        irq_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            irq_next[i % NUM_IRQ] = irq_next[i % NUM_IRQ] | (pend[i] & mask_q[i]);
        end
    end

    // NMI ignores MASK; the chosen source keeps its normal IRQ routing too
    assign nmi_next = nmi_en_q & pend_w[nmi_idx_q];

    // Register core-facing outputs so they are glitch free
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q <= '0;
            nmi_q <= 1'b0;
        end else begin
            irq_q <= irq_next;
            nmi_q <= nmi_next;
        end
    end

    assign IRQ       = irq_q;
    assign NMI       = nmi_q;
    assign HRESP     = hresp_q;
    assign HREADYOUT = hreadyout_q;
    assign HRDATA    = rdata;

endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: directed latency/priority/error checks plus random traffic against a behavioural model.
// Latency: n/a.
// Backpressure: bus tasks wait on HREADYOUT with a bounded cycle budget.
module tb_irq_aggregator;

    localparam logic [11:0] A_RAW   = 12'h000;
    localparam logic [11:0] A_PEND  = 12'h004;
    localparam logic [11:0] A_MASK  = 12'h008;
    localparam logic [11:0] A_MODE  = 12'h00C;
    localparam logic [11:0] A_POL   = 12'h010;
    localparam logic [11:0] A_SWSET = 12'h014;
    localparam logic [11:0] A_NMI   = 12'h018;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [11:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [3:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] irq_src;
    logic [15:0] IRQ;
    logic        NMI;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_src, m_mask, m_mode, m_pol, m_pq;
    logic        m_nmi_en;
    logic [4:0]  m_nmi_idx;

    irq_aggregator #(.NUM_SRC(32), .NUM_IRQ(16), .ADDR_W(12)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADYOUT),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .irq_src   (irq_src),
        .IRQ       (IRQ),
        .NMI       (NMI)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_xfer(input logic wr, input logic [11:0] addr, input logic [3:0] size,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err_first, output logic err_last, output int waits);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        tick();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = wdata;
        err_first = HRESP;
        waits = 0;
        while (!HREADYOUT && waits < 8) begin
            tick();
            waits++;
        end
        if (waits >= 8) chk("bus_timeout", waits, 0);
        err_last = HRESP;
        rdata    = HRDATA;
        tick();
    endtask

    task automatic reg_wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        e1, e2;
        int          w;
        bus_xfer(1'b1, addr, 4'd2, data, rd, e1, e2, w);
    endtask

    task automatic reg_rd(input logic [11:0] addr, output logic [31:0] data);
        logic e1, e2;
        int   w;
        bus_xfer(1'b0, addr, 4'd2, 32'h0, data, e1, e2, w);
    endtask

    function automatic logic [31:0] exp_pend();
        return m_pq | ((m_src ^ m_pol) & ~m_mode);
    endfunction

    function automatic logic [15:0] exp_irq();
        logic [31:0] p;
        p = exp_pend() & m_mask;
        return p[15:0] | p[31:16];
    endfunction

    function automatic logic exp_nmi();
        logic [31:0] p;
        p = exp_pend();
        return m_nmi_en & p[m_nmi_idx];
    endfunction

    initial begin
        logic [31:0] d, r, old_act;
        logic        e1, e2;
        int          w;
        int          op;

        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 4'd2;
        HWDATA  = '0;
        irq_src = '0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Reset state
        chk("rst_irq", IRQ, 0);
        chk("rst_nmi", NMI, 0);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hrdata", HRDATA, 0);
        for (int a = 0; a < 7; a++) begin
            reg_rd(12'(a * 4), d);
            chk($sformatf("rst_reg_%0h", a * 4), d, 0);
        end

        // Level mode routing: source 16 folds onto IRQ[0]
        reg_wr(A_MASK, 32'h0001_0001);
        reg_wr(A_MODE, 32'h0);
        irq_src[16] = 1'b1;
        repeat (2) tick();
        chk("lvl_rise_e2", IRQ[0], 0);
        tick();
        chk("lvl_rise_e3", IRQ[0], 1);
        reg_rd(A_RAW, d);
        chk("lvl_raw", d, 32'h0001_0000);
        irq_src[16] = 1'b0;
        repeat (2) tick();
        chk("lvl_fall_e2", IRQ[0], 1);
        tick();
        chk("lvl_fall_e3", IRQ[0], 0);

        // Edge mode: 3-cycle pulse on source 3
        reg_wr(A_MASK, 32'h8);
        reg_wr(A_MODE, 32'h8);
        irq_src[3] = 1'b1;
        repeat (3) tick();
        chk("edg_e3", IRQ[3], 0);
        irq_src[3] = 1'b0;
        tick();
        chk("edg_e4", IRQ[3], 1);
        repeat (4) tick();
        chk("edg_hold", IRQ[3], 1);
        reg_rd(A_PEND, d);
        chk("edg_pend", d, 32'h8);
        reg_wr(A_PEND, 32'h8);
        chk("w1c_same_edge", IRQ[3], 1);
        tick();
        chk("w1c_next_edge", IRQ[3], 0);

        // New edge landing on the W1C commit edge keeps the bit set
        irq_src[3] = 1'b1;
        repeat (3) tick();
        irq_src[3] = 1'b0;
        repeat (4) tick();
        reg_rd(A_PEND, d);
        chk("coin_pre", d, 32'h8);
        irq_src[3] = 1'b1;
        tick();
        reg_wr(A_PEND, 32'h8);
        reg_rd(A_PEND, d);
        chk("coin_set_wins", d, 32'h8);
        irq_src[3] = 1'b0;
        repeat (4) tick();

        // Polarity and NMI steering on source 5
        irq_src[5] = 1'b1;
        repeat (3) tick();
        reg_wr(A_POL, 32'h20);
        reg_wr(A_NMI, 32'h85);
        reg_rd(A_NMI, d);
        chk("nmi_readback", d, 32'h85);
        chk("nmi_pre", NMI, 0);
        irq_src[5] = 1'b0;
        repeat (2) tick();
        chk("nmi_e2", NMI, 0);
        tick();
        chk("nmi_e3", NMI, 1);
        reg_wr(A_NMI, 32'h05);
        tick();
        chk("nmi_disabled", NMI, 0);
        reg_wr(A_NMI, 32'hFFFF_FFFF);
        reg_rd(A_NMI, d);
        chk("nmi_sel_bits", d, 32'h9F);
        reg_wr(A_NMI, 32'h0);

        // Software set and W1C; level bit 5 survives W1C
        reg_wr(A_PEND, 32'h8);
        reg_wr(A_MASK, 32'h100);
        reg_wr(A_SWSET, 32'h100);
        chk("sw_e0", IRQ[8], 0);
        tick();
        chk("sw_e1", IRQ[8], 1);
        reg_rd(A_PEND, d);
        chk("sw_pend", d, 32'h120);
        reg_rd(A_SWSET, d);
        chk("sw_reads_zero", d, 0);
        reg_wr(A_PEND, 32'h120);
        reg_rd(A_PEND, d);
        chk("sw_w1c", d, 32'h20);
        chk("sw_irq_clear", IRQ[8], 0);

        // Error responses
        bus_xfer(1'b0, 12'h01C, 4'd2, 32'h0, d, e1, e2, w);
        chk("err_rd_first", e1, 1);
        chk("err_rd_last", e2, 1);
        chk("err_rd_waits", w, 1);
        chk("err_rd_data", d, 0);
        bus_xfer(1'b1, A_MASK, 4'd0, 32'hFFFF_FFFF, d, e1, e2, w);
        chk("err_byte_first", e1, 1);
        chk("err_byte_waits", w, 1);
        bus_xfer(1'b0, A_MASK, 4'd2, 32'h0, d, e1, e2, w);
        chk("ok_after_err_resp", {e1, e2}, 0);
        chk("ok_after_err_waits", w, 0);
        chk("mask_unchanged", d, 32'h100);

        // Back-to-back write then read of MASK
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_MASK; HSIZE = 4'd2;
        tick();
        HWDATA = 32'h0000_A5A5;
        HWRITE = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("b2b_read", HRDATA, 32'h0000_A5A5);
        tick();
        chk("b2b_irq5", IRQ[5], 1);

        // Asynchronous reset during the first ERROR cycle
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 12'h020; HSIZE = 4'd2;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("mid_err1", {HRESP, HREADYOUT}, 32'h2);
        irq_src = '0;
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_resp", {HRESP, HREADYOUT}, 32'h1);
        chk("mid_rst_irq", IRQ, 0);
        tick();
        HRESETn = 1'b1;
        reg_rd(A_MASK, d);
        chk("mid_rst_mask", d, 0);
        reg_rd(A_POL, d);
        chk("mid_rst_pol", d, 0);

        // Random traffic against the behavioural model
        m_src = '0; m_mask = '0; m_mode = '0; m_pol = '0; m_pq = '0;
        m_nmi_en = 1'b0; m_nmi_idx = '0;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 7);
            r  = $urandom;
            old_act = m_src ^ m_pol;
            case (op)
                0, 1: begin
                    m_src   = m_src ^ (r & $urandom);
                    irq_src = m_src;
                    m_pq    = m_pq | ((m_src ^ m_pol) & ~old_act & m_mode);
                end
                2: begin reg_wr(A_MASK, r); m_mask = r; end
                3: begin reg_wr(A_MODE, r); m_mode = r; end
                4: begin
                    reg_wr(A_POL, r);
                    m_pol = r;
                    m_pq  = m_pq | ((m_src ^ m_pol) & ~old_act & m_mode);
                end
                5: begin
                    r = r & $urandom;
                    reg_wr(A_SWSET, r);
                    m_pq = m_pq | r;
                end
                6: begin reg_wr(A_PEND, r); m_pq = m_pq & ~r; end
                default: begin
                    reg_wr(A_NMI, r);
                    m_nmi_en  = r[7];
                    m_nmi_idx = r[4:0];
                end
            endcase
            repeat (6) tick();
            chk($sformatf("rnd%0d_irq", it), IRQ, exp_irq());
            chk($sformatf("rnd%0d_nmi", it), NMI, exp_nmi());
            reg_rd(A_PEND, d);
            chk($sformatf("rnd%0d_pend", it), d, exp_pend());
            reg_rd(A_RAW, d);
            chk($sformatf("rnd%0d_raw", it), d, m_src ^ m_pol);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
